// File: rtl/wb_dma_reader.sv
// wb_dma_reader: Wishbone burst reader that streams a linear block of 32-bit words
// through a first-word-fall-through FIFO to a valid/ready consumer.
module wb_dma_reader #(
    parameter int FIFO_AW   = 3,
    parameter int MAX_BURST = 4,
    parameter int LEN_W     = 16
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_n_i,
    input  logic             start_i,
    input  logic [31:0]      base_adr_i,
    input  logic [LEN_W-1:0] len_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o,
    output logic [31:0]      wb_adr_o,
    output logic [31:0]      wb_dat_o,
    input  logic [31:0]      wb_dat_i,
    output logic [3:0]       wb_sel_o,
    output logic [2:0]       wb_cti_o,
    output logic [1:0]       wb_bte_o,
    output logic             wb_cyc_o,
    output logic             wb_stb_o,
    output logic             wb_we_o,
    input  logic             wb_ack_i,
    input  logic             wb_err_i,
    output logic [31:0]      st_dat_o,
    output logic             st_valid_o,
    input  logic             st_ready_i
);
    // state | meaning
    // IDLE  | waiting for start_i
    // ARB   | sizing next burst, waiting for enough free FIFO slots
    // BURST | Wishbone incrementing burst in flight
    // DRAIN | bus finished, waiting for the consumer to empty the FIFO

    localparam int DEPTH = 2 ** FIFO_AW;
    localparam int BW    = $clog2(MAX_BURST + 1);

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INC     = 3'b010;
    localparam logic [2:0] CTI_END     = 3'b111;

    typedef enum logic [1:0] {IDLE, ARB, BURST, DRAIN} state_t;

    state_t             state;
    logic [LEN_W-1:0]   remaining;
    logic [BW-1:0]      beat_cnt;
    logic [LEN_W-1:0]   burst_len;
    logic [LEN_W-1:0]   free_slots;

    logic [31:0]        mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic [FIFO_AW:0]   count;
    logic               fifo_empty;
    logic               push;
    logic               pop;
    logic               bus_ack;
    logic               bus_err;
    logic               unused_adr_lsb;

    assign unused_adr_lsb = ^base_adr_i[1:0];

    assign wb_dat_o = '0;
    assign wb_sel_o = 4'hF;
    assign wb_bte_o = 2'b00;
    assign wb_we_o  = 1'b0;

    // Error wins over ack so an erroring beat never reaches the FIFO.
    assign bus_err = (state == BURST) && wb_cyc_o && wb_stb_o && wb_err_i;
    assign bus_ack = (state == BURST) && wb_cyc_o && wb_stb_o && wb_ack_i && !wb_err_i;

    assign fifo_empty = (count == '0);
    assign push       = bus_ack;
    assign pop        = !fifo_empty && st_ready_i;
    assign st_valid_o = !fifo_empty;
    assign st_dat_o   = mem[rd_ptr];

    assign free_slots = LEN_W'(DEPTH) - LEN_W'(count);

    always_comb begin
        burst_len = remaining;
        if (remaining > LEN_W'(MAX_BURST)) begin
            burst_len = LEN_W'(MAX_BURST);
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (push) begin
            mem[wr_ptr] <= wb_dat_i;
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state     <= IDLE;
            remaining <= '0;
            beat_cnt  <= '0;
            wb_adr_o  <= '0;
            wb_cti_o  <= CTI_CLASSIC;
            wb_cyc_o  <= 1'b0;
            wb_stb_o  <= 1'b0;
            busy_o    <= 1'b0;
            done_o    <= 1'b0;
            err_o     <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_i) begin
                        err_o <= 1'b0;
                        if (len_i == '0) begin
                            done_o <= 1'b1;
                        end else begin
                            wb_adr_o  <= {base_adr_i[31:2], 2'b00};
                            remaining <= len_i;
                            busy_o    <= 1'b1;
                            state     <= ARB;
                        end
                    end
                end
                ARB: begin
                    // Space is reserved up front, so no push can meet a full FIFO.
                    if (free_slots >= burst_len) begin
                        beat_cnt <= BW'(burst_len);
                        wb_cyc_o <= 1'b1;
                        wb_stb_o <= 1'b1;
                        wb_cti_o <= (burst_len == LEN_W'(1)) ? CTI_END : CTI_INC;
                        state    <= BURST;
                    end
                end
                BURST: begin
                    if (bus_err) begin
                        err_o     <= 1'b1;
                        wb_cyc_o  <= 1'b0;
                        wb_stb_o  <= 1'b0;
                        wb_cti_o  <= CTI_CLASSIC;
                        remaining <= '0;
                        state     <= DRAIN;
                    end else if (bus_ack) begin
                        wb_adr_o  <= wb_adr_o + 32'd4;
                        remaining <= remaining - 1'b1;
                        beat_cnt  <= beat_cnt - 1'b1;
                        if (beat_cnt == BW'(1)) begin
                            wb_cyc_o <= 1'b0;
                            wb_stb_o <= 1'b0;
                            wb_cti_o <= CTI_CLASSIC;
                            state    <= (remaining != LEN_W'(1)) ? ARB : DRAIN;
                        end else if (beat_cnt == BW'(2)) begin
                            wb_cti_o <= CTI_END;
                        end
                    end
                end
                DRAIN: begin
                    if (fifo_empty) begin
                        done_o <= 1'b1;
                        busy_o <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    fifo_no_overflow: assert property (@(posedge wb_clk_i) disable iff (!wb_rst_n_i)
        !(push && (count == (FIFO_AW + 1)'(DEPTH))));

endmodule

// File: tb/tb_wb_dma_reader.sv
// Directed bench for wb_dma_reader: behavioural Wishbone slave, stream monitor
// and one task per scenario with hand-computed expectations.
module tb_wb_dma_reader;
    localparam int FIFO_AW   = 3;
    localparam int MAX_BURST = 4;
    localparam int LEN_W     = 16;

    logic             wb_clk_i   = 1'b0;
    logic             wb_rst_n_i = 1'b0;
    logic             start_i    = 1'b0;
    logic [31:0]      base_adr_i = '0;
    logic [LEN_W-1:0] len_i      = '0;
    logic             busy_o, done_o, err_o;
    logic [31:0]      wb_adr_o, wb_dat_o;
    logic [31:0]      wb_dat_i   = '0;
    logic [3:0]       wb_sel_o;
    logic [2:0]       wb_cti_o;
    logic [1:0]       wb_bte_o;
    logic             wb_cyc_o, wb_stb_o, wb_we_o;
    logic             wb_ack_i   = 1'b0;
    logic             wb_err_i   = 1'b0;
    logic [31:0]      st_dat_o;
    logic             st_valid_o;
    logic             st_ready_i = 1'b0;

    int checks = 0;
    int errors = 0;

    int ack_gap = 0;
    int err_at  = -1;
    int s_wait  = 0;
    int s_beat  = 0;

    logic [31:0] beat_adr[$];
    logic [2:0]  beat_cti[$];
    logic [31:0] pop_dat[$];
    int          pop_cyc[$];
    int          done_cyc[$];
    int          rise_occ[$];
    int          occ = 0;
    int          max_occ = 0;
    int          cyc_n = 0;
    logic        prev_cyc = 1'b0;

    wb_dma_reader #(.FIFO_AW(FIFO_AW), .MAX_BURST(MAX_BURST), .LEN_W(LEN_W)) dut (
        .wb_clk_i(wb_clk_i), .wb_rst_n_i(wb_rst_n_i),
        .start_i(start_i), .base_adr_i(base_adr_i), .len_i(len_i),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
        .wb_sel_o(wb_sel_o), .wb_cti_o(wb_cti_o), .wb_bte_o(wb_bte_o),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
        .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i),
        .st_dat_o(st_dat_o), .st_valid_o(st_valid_o), .st_ready_i(st_ready_i)
    );

    initial forever #5 wb_clk_i = ~wb_clk_i;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    // Slave: ack after ack_gap wait states, optional error on beat err_at of a cycle.
    initial forever begin
        @(posedge wb_clk_i);
        #1;
        wb_ack_i = 1'b0;
        wb_err_i = 1'b0;
        if (wb_rst_n_i && wb_cyc_o && wb_stb_o) begin
            if (s_wait >= ack_gap) begin
                s_wait = 0;
                if (s_beat == err_at) begin
                    wb_err_i = 1'b1;
                end else begin
                    wb_ack_i = 1'b1;
                    wb_dat_i = mem_word(wb_adr_o);
                end
                s_beat++;
            end else begin
                s_wait++;
            end
        end else begin
            s_wait = 0;
            s_beat = 0;
        end
    end

    initial forever begin
        @(negedge wb_clk_i);
        cyc_n++;
        if (!wb_rst_n_i) begin
            occ      = 0;
            prev_cyc = 1'b0;
        end else begin
            if (wb_cyc_o && !prev_cyc) rise_occ.push_back(occ);
            prev_cyc = wb_cyc_o;
            if (wb_cyc_o && wb_stb_o && wb_ack_i && !wb_err_i) begin
                beat_adr.push_back(wb_adr_o);
                beat_cti.push_back(wb_cti_o);
                occ++;
            end
            if (st_valid_o && st_ready_i) begin
                pop_dat.push_back(st_dat_o);
                pop_cyc.push_back(cyc_n);
                occ--;
            end
            if (done_o) done_cyc.push_back(cyc_n);
            if (occ > max_occ) max_occ = occ;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_logs();
        beat_adr.delete();
        beat_cti.delete();
        pop_dat.delete();
        pop_cyc.delete();
        done_cyc.delete();
        rise_occ.delete();
        max_occ = occ;
    endtask

    task automatic pulse_start(input logic [31:0] base, input int len);
        @(posedge wb_clk_i);
        #1;
        base_adr_i = base;
        len_i      = LEN_W'(len);
        start_i    = 1'b1;
        @(posedge wb_clk_i);
        #1;
        start_i    = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge wb_clk_i);
            #2;
            if (done_o) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        logic [6:0] ctl;
        wb_rst_n_i = 1'b0;
        repeat (3) @(posedge wb_clk_i);
        #2;
        ctl = {busy_o, done_o, err_o, wb_cyc_o, wb_stb_o, wb_we_o, st_valid_o};
        checks++;
        if (ctl !== 7'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected %b", ctl, 7'b0);
        end
        checks++;
        if (wb_adr_o !== 32'h0 || wb_cti_o !== 3'b000) begin
            errors++;
            $display("FAIL reset_bus: got adr %h cti %b expected adr 0 cti 000", wb_adr_o, wb_cti_o);
        end
        checks++;
        if (wb_sel_o !== 4'hF || wb_bte_o !== 2'b00 || wb_dat_o !== 32'h0) begin
            errors++;
            $display("FAIL const_outs: got sel %h bte %b dat %h expected F 00 0", wb_sel_o, wb_bte_o, wb_dat_o);
        end
        @(posedge wb_clk_i);
        #1;
        wb_rst_n_i = 1'b1;
        repeat (2) @(posedge wb_clk_i);
    endtask

    task automatic test_basic();
        bit ok;
        logic [31:0] exp_adr;
        logic [2:0]  exp_cti;
        ack_gap = 1; err_at = -1; st_ready_i = 1'b1;
        clear_logs();
        pulse_start(32'h0000_0101, 3);
        checks++;
        if (busy_o !== 1'b1) begin
            errors++;
            $display("FAIL basic_busy: got %b expected 1", busy_o);
        end
        wait_done(100, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL basic_done_timeout: got no done expected done within 100 cycles");
        end
        checks++;
        if (busy_o !== 1'b0) begin
            errors++;
            $display("FAIL basic_busy_end: got %b expected 0", busy_o);
        end
        @(negedge wb_clk_i);
        #1;
        checks++;
        if (beat_adr.size() != 3) begin
            errors++;
            $display("FAIL basic_beats: got %0d expected 3", beat_adr.size());
        end
        for (int i = 0; i < 3; i++) begin
            exp_adr = 32'h100 + 32'(4 * i);
            exp_cti = (i == 2) ? 3'b111 : 3'b010;
            checks++;
            if (beat_adr[i] !== exp_adr || beat_cti[i] !== exp_cti) begin
                errors++;
                $display("FAIL basic_beat%0d: got adr %h cti %b expected adr %h cti %b",
                         i, beat_adr[i], beat_cti[i], exp_adr, exp_cti);
            end
            checks++;
            if (pop_dat[i] !== mem_word(exp_adr)) begin
                errors++;
                $display("FAIL basic_word%0d: got %h expected %h", i, pop_dat[i], mem_word(exp_adr));
            end
        end
        checks++;
        if (done_cyc.size() != 1 || pop_cyc.size() != 3 || done_cyc[0] - pop_cyc[2] != 2) begin
            errors++;
            $display("FAIL basic_done_timing: got %0d done pulses, %0d pops expected 1 pulse 2 cycles after 3rd pop",
                     done_cyc.size(), pop_cyc.size());
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        bit found;
        logic [2:0] exp_cti;
        ack_gap = 0; err_at = -1; st_ready_i = 1'b0;
        clear_logs();
        pulse_start(32'h0000_2000, 10);
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge wb_clk_i);
            #2;
            if (occ == 8) begin
                found = 1'b1;
                break;
            end
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL bp_fill_timeout: got occupancy %0d expected 8", occ);
        end
        repeat (10) @(posedge wb_clk_i);
        #2;
        checks++;
        if (beat_adr.size() != 8 || wb_cyc_o !== 1'b0 || busy_o !== 1'b1 || st_valid_o !== 1'b1) begin
            errors++;
            $display("FAIL bp_stall: got beats %0d cyc %b busy %b valid %b expected 8 0 1 1",
                     beat_adr.size(), wb_cyc_o, busy_o, st_valid_o);
        end
        st_ready_i = 1'b1;
        wait_done(200, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL bp_done_timeout: got no done expected done within 200 cycles");
        end
        @(negedge wb_clk_i);
        #1;
        checks++;
        if (beat_adr.size() != 10 || pop_dat.size() != 10) begin
            errors++;
            $display("FAIL bp_count: got beats %0d words %0d expected 10 10", beat_adr.size(), pop_dat.size());
        end
        for (int i = 0; i < 10; i++) begin
            exp_cti = (i == 3 || i == 7 || i == 9) ? 3'b111 : 3'b010;
            checks++;
            if (beat_adr[i] !== 32'h2000 + 32'(4 * i) || beat_cti[i] !== exp_cti ||
                pop_dat[i] !== mem_word(32'h2000 + 32'(4 * i))) begin
                errors++;
                $display("FAIL bp_beat%0d: got adr %h cti %b word %h expected adr %h cti %b word %h",
                         i, beat_adr[i], beat_cti[i], pop_dat[i], 32'h2000 + 32'(4 * i), exp_cti,
                         mem_word(32'h2000 + 32'(4 * i)));
            end
        end
        checks++;
        if (rise_occ.size() != 3 || rise_occ[2] > 6 || max_occ > 8) begin
            errors++;
            $display("FAIL bp_bursts: got %0d bursts, occupancy at last launch %0d, max %0d expected 3, <=6, <=8",
                     rise_occ.size(), rise_occ[2], max_occ);
        end
    endtask

    task automatic test_zero_len();
        st_ready_i = 1'b1;
        clear_logs();
        pulse_start(32'h0000_0700, 0);
        checks++;
        if (done_o !== 1'b1 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL zero_done: got done %b busy %b expected 1 0", done_o, busy_o);
        end
        @(posedge wb_clk_i);
        #1;
        checks++;
        if (done_o !== 1'b0) begin
            errors++;
            $display("FAIL zero_pulse: got done %b expected 0", done_o);
        end
        repeat (5) @(posedge wb_clk_i);
        #2;
        checks++;
        if (rise_occ.size() != 0 || wb_cyc_o !== 1'b0) begin
            errors++;
            $display("FAIL zero_bus: got %0d cycles cyc %b expected 0 0", rise_occ.size(), wb_cyc_o);
        end
    endtask

    task automatic test_bus_err();
        bit ok;
        bit found;
        ack_gap = 0; err_at = 1; st_ready_i = 1'b1;
        clear_logs();
        pulse_start(32'h0000_0300, 4);
        found = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(posedge wb_clk_i);
            #2;
            if (wb_err_i) begin
                found = 1'b1;
                break;
            end
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL err_timeout: got no wb_err_i expected one within 50 cycles");
        end
        @(posedge wb_clk_i);
        #1;
        checks++;
        if (wb_cyc_o !== 1'b0 || wb_stb_o !== 1'b0 || err_o !== 1'b1) begin
            errors++;
            $display("FAIL err_drop: got cyc %b stb %b err %b expected 0 0 1", wb_cyc_o, wb_stb_o, err_o);
        end
        wait_done(50, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL err_done_timeout: got no done expected done within 50 cycles");
        end
        @(negedge wb_clk_i);
        #1;
        checks++;
        if (pop_dat.size() != 1 || pop_dat[0] !== mem_word(32'h300) || beat_adr.size() != 1 || err_o !== 1'b1) begin
            errors++;
            $display("FAIL err_words: got words %0d first %h beats %0d err %b expected 1 %h 1 1",
                     pop_dat.size(), pop_dat[0], beat_adr.size(), err_o, mem_word(32'h300));
        end
        err_at = -1;
        clear_logs();
        pulse_start(32'h0000_0400, 1);
        checks++;
        if (err_o !== 1'b0 || busy_o !== 1'b1) begin
            errors++;
            $display("FAIL err_clear: got err %b busy %b expected 0 1", err_o, busy_o);
        end
        wait_done(50, ok);
        @(negedge wb_clk_i);
        #1;
        checks++;
        if (!ok || pop_dat.size() != 1 || pop_dat[0] !== mem_word(32'h400)) begin
            errors++;
            $display("FAIL err_restart: got done %b words %0d first %h expected 1 1 %h",
                     ok, pop_dat.size(), pop_dat[0], mem_word(32'h400));
        end
    endtask

    task automatic test_reset_mid_burst();
        bit ok;
        ack_gap = 1; err_at = -1; st_ready_i = 1'b0;
        clear_logs();
        pulse_start(32'h0000_0500, 8);
        for (int i = 0; i < 50 && beat_adr.size() < 2; i++) begin
            @(posedge wb_clk_i);
            #2;
        end
        checks++;
        if (wb_cyc_o !== 1'b1 || st_valid_o !== 1'b1) begin
            errors++;
            $display("FAIL rst_pre: got cyc %b valid %b expected 1 1", wb_cyc_o, st_valid_o);
        end
        #1;
        wb_rst_n_i = 1'b0;
        #1;
        checks++;
        if (wb_cyc_o !== 1'b0 || wb_stb_o !== 1'b0 || st_valid_o !== 1'b0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL rst_async: got cyc %b stb %b valid %b busy %b expected 0 0 0 0",
                     wb_cyc_o, wb_stb_o, st_valid_o, busy_o);
        end
        repeat (2) @(posedge wb_clk_i);
        #1;
        wb_rst_n_i = 1'b1;
        repeat (2) @(posedge wb_clk_i);
        #2;
        checks++;
        if (wb_cyc_o !== 1'b0 || busy_o !== 1'b0 || st_valid_o !== 1'b0 || err_o !== 1'b0) begin
            errors++;
            $display("FAIL rst_idle: got cyc %b busy %b valid %b err %b expected 0 0 0 0",
                     wb_cyc_o, busy_o, st_valid_o, err_o);
        end
        ack_gap = 0; st_ready_i = 1'b1;
        clear_logs();
        pulse_start(32'hFFFF_FFFC, 1);
        wait_done(50, ok);
        @(negedge wb_clk_i);
        #1;
        checks++;
        if (!ok || beat_adr.size() != 1 || beat_adr[0] !== 32'hFFFF_FFFC || beat_cti[0] !== 3'b111) begin
            errors++;
            $display("FAIL rst_top_beat: got done %b beats %0d adr %h cti %b expected 1 1 fffffffc 111",
                     ok, beat_adr.size(), beat_adr[0], beat_cti[0]);
        end
        checks++;
        if (pop_dat.size() != 1 || pop_dat[0] !== mem_word(32'hFFFF_FFFC)) begin
            errors++;
            $display("FAIL rst_top_word: got words %0d first %h expected 1 %h",
                     pop_dat.size(), pop_dat[0], mem_word(32'hFFFF_FFFC));
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        bit found;
        ack_gap = 2; err_at = -1; st_ready_i = 1'b0;
        clear_logs();
        pulse_start(32'h0000_0600, 9);
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge wb_clk_i);
            #2;
            if (occ == 7 && wb_ack_i && wb_cyc_o) begin
                found = 1'b1;
                break;
            end
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL b2b_sync_timeout: got occupancy %0d expected 7 with ack pending", occ);
        end
        st_ready_i = 1'b1;
        @(posedge wb_clk_i);
        #1;
        st_ready_i = 1'b0;
        pulse_start(32'h0000_0900, 2);
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge wb_clk_i);
            #2;
            if (beat_adr.size() == 9) begin
                found = 1'b1;
                break;
            end
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL b2b_last_burst: got %0d beats expected 9 with FIFO holding 7", beat_adr.size());
        end
        repeat (5) @(posedge wb_clk_i);
        #2;
        checks++;
        if (rise_occ.size() != 3 || rise_occ[2] != 7 || wb_cyc_o !== 1'b0 || pop_dat.size() != 1) begin
            errors++;
            $display("FAIL b2b_hold7: got bursts %0d launch occupancy %0d cyc %b words %0d expected 3 7 0 1",
                     rise_occ.size(), rise_occ[2], wb_cyc_o, pop_dat.size());
        end
        st_ready_i = 1'b1;
        wait_done(100, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL b2b_done_timeout: got no done expected done within 100 cycles");
        end
        repeat (5) @(posedge wb_clk_i);
        #2;
        checks++;
        if (pop_dat.size() != 9 || beat_adr.size() != 9 || done_cyc.size() != 1 || max_occ > 8 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL b2b_totals: got words %0d beats %0d dones %0d max %0d busy %b expected 9 9 1 <=8 0",
                     pop_dat.size(), beat_adr.size(), done_cyc.size(), max_occ, busy_o);
        end
        for (int i = 0; i < 9; i++) begin
            checks++;
            if (pop_dat[i] !== mem_word(32'h600 + 32'(4 * i)) || beat_adr[i] !== 32'h600 + 32'(4 * i)) begin
                errors++;
                $display("FAIL b2b_order%0d: got word %h adr %h expected word %h adr %h",
                         i, pop_dat[i], beat_adr[i], mem_word(32'h600 + 32'(4 * i)), 32'h600 + 32'(4 * i));
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_zero_len();
        test_bus_err();
        test_reset_mid_burst();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
